// File: rtl/debounce_pulse_array.sv
// debounce_pulse_array: N independent channels. Each channel synchronises a raw
// button/switch input, debounces it and emits one-cycle registered pulses on
// the selected edge(s). It can also auto-repeat while the input is held high.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset; all state clears to 0 / IDLE
//   in_trig    [N] raw asynchronous trigger inputs
//   out_pulse  [N] one-cycle event pulses (registered)
//   level      [N] debounced level per channel
//   held       [N] 1 while the channel is auto-repeating (REPEAT state)
//
// Latency: an input held stable from clock edge k raises level after edge
// k+SYNC_STAGES+DEB_CYCLES-1. The press pulse follows edge
// k+SYNC_STAGES+DEB_CYCLES.

module debounce_pulse_array #(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 16,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_trig,
  output logic [N-1:0] out_pulse,
  output logic [N-1:0] level,
  output logic [N-1:0] held
);

  localparam int CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   lvl_d;
    logic [CNT_W-1:0]       cnt;
    logic                   rise;
    logic                   fall;
    logic                   edge_term;
    logic                   rpt_fire;
    logic                   pulse_q;
    rpt_state_t             state;
    logic [TMR_W-1:0]       timer;

    // Synchroniser chain. Bit 0 takes the raw pin and the top bit is the
    // synchronised sample.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in_trig[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted only after DEB_CYCLES consecutive
    // samples disagree with the current level. Any agreeing sample restarts
    // the count, so short glitches never get through.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (s == lvl) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        lvl <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    // Edge selection. Any unsupported mode value falls back to rising-edge.
    always_comb begin
      edge_term = rise;
      if (EDGE_MODE == 1) begin
        edge_term = fall;
      end else if (EDGE_MODE == 2) begin
        edge_term = rise | fall;
      end
    end

    // A repeat pulse fires on the cycle the timer expires. A released
    // button (lvl low) suppresses it, because release takes priority over
    // expiry.
    always_comb begin
      rpt_fire = 1'b0;
      if (REPEAT_EN != 0 && lvl) begin
        if (state == ST_HOLD && timer == HOLD_LAST) begin
          rpt_fire = 1'b1;
        end else if (state == ST_REPEAT && timer == RPT_LAST) begin
          rpt_fire = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_d   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        lvl_d   <= lvl;
        pulse_q <= edge_term | rpt_fire;
      end
    end

    // Auto-repeat FSM. Without REPEAT_EN it never leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            timer <= '0;
            if (REPEAT_EN != 0 && rise) begin
              state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!lvl) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == HOLD_LAST) begin
              state <= ST_REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!lvl) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == RPT_LAST) begin
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end

    assign out_pulse[i] = pulse_q;
    assign level[i]     = lvl;
    assign held[i]      = (state == ST_REPEAT);
  end

endmodule

// File: tb/tb_debounce_pulse_array.sv
// Directed testbench for debounce_pulse_array. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge. Step t samples the state
// after clock edge t, where edge 0 is the first edge to see the new input.

module tb_debounce_pulse_array;

  logic       clk;
  logic       rst_n;

  logic [3:0] in_a;
  logic [3:0] out_pulse_a;
  logic [3:0] level_a;
  logic [3:0] held_a;

  logic [0:0] in_b;
  logic [0:0] out_pulse_b;
  logic [0:0] level_b;
  logic [0:0] held_b;

  logic [0:0] in_c;
  logic [0:0] out_pulse_c;
  logic [0:0] level_c;
  logic [0:0] held_c;

  int errors;
  int checks;

  // Default configuration: 4 channels, rising edge, no repeat.
  debounce_pulse_array dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_trig   (in_a),
    .out_pulse (out_pulse_a),
    .level     (level_a),
    .held      (held_a)
  );

  // Both-edge mode with a short debounce.
  debounce_pulse_array #(
    .N          (1),
    .DEB_CYCLES (4),
    .EDGE_MODE  (2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_trig   (in_b),
    .out_pulse (out_pulse_b),
    .level     (level_b),
    .held      (held_b)
  );

  // Auto-repeat configuration.
  debounce_pulse_array #(
    .N             (1),
    .DEB_CYCLES    (4),
    .REPEAT_EN     (1),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (3)
  ) dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_trig   (in_c),
    .out_pulse (out_pulse_c),
    .level     (level_c),
    .held      (held_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_pulse_a !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulse_a: got %b expected 0000", out_pulse_a);
    end
    checks++;
    if (level_a !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level_a: got %b expected 0000", level_a);
    end
    checks++;
    if (held_c !== 1'b0 || out_pulse_c !== 1'b0 || level_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_c: got pulse=%b level=%b held=%b expected all 0",
               out_pulse_c, level_c, held_c);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_pulse_a !== 4'b0000 || level_a !== 4'b0000 || held_a !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: got pulse=%b level=%b held=%b expected 0",
               out_pulse_a, level_a, held_a);
    end
  endtask

  task automatic test_clean_press();
    int first_lvl   = -1;
    int first_pulse = -1;
    int npulse      = 0;
    int lvl_fall    = -1;
    int nother      = 0;
    for (int t = 0; t < 120; t++) begin
      in_a[0] = (t < 100);
      @(negedge clk);
      if (out_pulse_a[0]) begin
        npulse++;
        if (first_pulse < 0) first_pulse = t;
      end
      if (level_a[0] && first_lvl < 0) first_lvl = t;
      if (t >= 100 && !level_a[0] && lvl_fall < 0) lvl_fall = t;
      if (out_pulse_a[3:1] != 3'b000 || level_a[3:1] != 3'b000) nother++;
    end
    checks++;
    if (first_lvl !== 17) begin
      errors++;
      $display("FAIL clean_level_rise: got %0d expected 17", first_lvl);
    end
    checks++;
    if (first_pulse !== 18) begin
      errors++;
      $display("FAIL clean_pulse_at: got %0d expected 18", first_pulse);
    end
    checks++;
    if (npulse !== 1) begin
      errors++;
      $display("FAIL clean_pulse_count: got %0d expected 1", npulse);
    end
    checks++;
    if (lvl_fall !== 117) begin
      errors++;
      $display("FAIL clean_level_fall: got %0d expected 117", lvl_fall);
    end
    checks++;
    if (nother !== 0) begin
      errors++;
      $display("FAIL clean_other_channels: got %0d active cycles expected 0", nother);
    end
  endtask

  task automatic test_bounce();
    int first_pulse = -1;
    int npulse      = 0;
    for (int t = 0; t < 100; t++) begin
      in_a[1] = (t < 60) ? (((t / 5) % 2) == 0) : 1'b1;
      @(negedge clk);
      if (out_pulse_a[1]) begin
        npulse++;
        if (first_pulse < 0) first_pulse = t;
      end
    end
    for (int t = 0; t < 25; t++) begin
      in_a[1] = 1'b0;
      @(negedge clk);
      if (out_pulse_a[1]) npulse++;
    end
    checks++;
    if (first_pulse !== 78) begin
      errors++;
      $display("FAIL bounce_pulse_at: got %0d expected 78", first_pulse);
    end
    checks++;
    if (npulse !== 1) begin
      errors++;
      $display("FAIL bounce_pulse_count: got %0d expected 1", npulse);
    end
    checks++;
    if (level_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_release_level: got %b expected 0", level_a[1]);
    end
  endtask

  task automatic test_edge_both();
    int pos[4];
    int npulse = 0;
    int lvl_fall = -1;
    for (int t = 0; t < 46; t++) begin
      in_b[0] = (t < 20);
      @(negedge clk);
      if (out_pulse_b[0]) begin
        if (npulse < 4) pos[npulse] = t;
        npulse++;
      end
      if (t >= 20 && !level_b[0] && lvl_fall < 0) lvl_fall = t;
    end
    checks++;
    if (npulse !== 2) begin
      errors++;
      $display("FAIL both_pulse_count: got %0d expected 2", npulse);
    end else begin
      checks++;
      if (pos[0] !== 6 || pos[1] !== 26) begin
        errors++;
        $display("FAIL both_pulse_at: got %0d,%0d expected 6,26", pos[0], pos[1]);
      end
    end
    checks++;
    if (lvl_fall !== 25) begin
      errors++;
      $display("FAIL both_level_fall: got %0d expected 25", lvl_fall);
    end
  endtask

  task automatic test_repeat();
    int exp_pos[8] = '{6, 16, 19, 22, 25, 28, 31, 34};
    int pos[16];
    int npulse = 0;
    int held_first = -1;
    int held_last  = -1;
    int bad = 0;
    for (int t = 0; t < 50; t++) begin
      in_c[0] = (t < 30);
      @(negedge clk);
      if (out_pulse_c[0]) begin
        if (npulse < 16) pos[npulse] = t;
        npulse++;
      end
      if (held_c[0]) begin
        if (held_first < 0) held_first = t;
        held_last = t;
      end
    end
    checks++;
    if (npulse !== 8) begin
      errors++;
      $display("FAIL repeat_pulse_count: got %0d expected 8", npulse);
    end else begin
      for (int j = 0; j < 8; j++) if (pos[j] != exp_pos[j]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL repeat_pulse_at: %0d positions wrong, got %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                 bad, pos[0], pos[1], pos[2], pos[3], pos[4], pos[5], pos[6], pos[7]);
      end
    end
    checks++;
    if (held_first !== 16) begin
      errors++;
      $display("FAIL repeat_held_rise: got %0d expected 16", held_first);
    end
    checks++;
    if (held_last !== 35) begin
      errors++;
      $display("FAIL repeat_held_last: got %0d expected 35", held_last);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int first_pulse = -1;
    int npulse = 0;
    int first_lvl = -1;
    for (int t = 0; t < 20; t++) begin
      in_c[0] = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (out_pulse_c[0] !== 1'b1 || held_c[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrep_before: got pulse=%b held=%b expected 1 1",
               out_pulse_c[0], held_c[0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_pulse_c[0] !== 1'b0 || level_c[0] !== 1'b0 || held_c[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrep_async_reset: got pulse=%b level=%b held=%b expected 0 0 0",
               out_pulse_c[0], level_c[0], held_c[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 13; t++) begin
      in_c[0] = 1'b1;
      @(negedge clk);
      if (out_pulse_c[0]) begin
        npulse++;
        if (first_pulse < 0) first_pulse = t;
      end
      if (level_c[0] && first_lvl < 0) first_lvl = t;
    end
    checks++;
    if (first_pulse !== 6 || npulse !== 1) begin
      errors++;
      $display("FAIL midrep_restart_pulse: got at %0d count %0d expected at 6 count 1",
               first_pulse, npulse);
    end
    checks++;
    if (first_lvl !== 5) begin
      errors++;
      $display("FAIL midrep_restart_level: got %0d expected 5", first_lvl);
    end
    in_c[0] = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int dur[3] = '{30, 40, 50};
    int fp[4]  = '{-1, -1, -1, -1};
    int np[4]  = '{0, 0, 0, 0};
    int fl[4]  = '{-1, -1, -1, -1};
    int fall2  = -1;
    for (int t = 0; t < 80; t++) begin
      for (int c = 0; c < 3; c++) in_a[c] = (t < dur[c]);
      in_a[3] = (t >= 5 && t < 10);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (out_pulse_a[c]) begin
          np[c]++;
          if (fp[c] < 0) fp[c] = t;
        end
        if (level_a[c] && fl[c] < 0) fl[c] = t;
      end
      if (t >= 50 && !level_a[2] && fall2 < 0) fall2 = t;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (fp[c] !== 18 || np[c] !== 1 || fl[c] !== 17) begin
        errors++;
        $display("FAIL simul_ch%0d: got pulse at %0d count %0d level at %0d expected 18 1 17",
                 c, fp[c], np[c], fl[c]);
      end
    end
    checks++;
    if (np[3] !== 0 || fl[3] !== -1) begin
      errors++;
      $display("FAIL simul_glitch_ch3: got %0d pulses level at %0d expected 0 pulses no level",
               np[3], fl[3]);
    end
    checks++;
    if (fall2 !== 67) begin
      errors++;
      $display("FAIL simul_release_ch2: got %0d expected 67", fall2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_c   = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_edge_both();
    test_repeat();
    test_reset_mid_repeat();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_array.md
# debounce_pulse_array

Parametrised N-channel successor to the single-channel edge-to-pulse generator. Each channel synchronises an asynchronous push-button/switch input, debounces it, and emits single-cycle pulses on selected edges, optionally with hold-to-auto-repeat. It sits between board I/O pins and the lab FSMs/counters that consume one-cycle key events.

## Interface
- N, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEB_CYCLES, 16: consecutive stable cycles required to accept a new level (≥1)
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = both edges produce a pulse
- REPEAT_EN, 0: 1 enables auto-repeat while the debounced level is held high
- HOLD_CYCLES, 1000: cycles from the press pulse to the first repeat pulse (≥1)
- REPEAT_CYCLES, 200: cycles between subsequent repeat pulses (≥1)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_trig  input  N  raw asynchronous trigger inputs
- out_pulse  output  N  one-cycle event pulses, registered
- level  output  N  debounced level per channel
- held  output  N  1 while the channel is in the REPEAT state

## Operation
- Per channel, fully independent; no cross-channel interaction.
- Sync: in_trig[i] passes through an SYNC_STAGES flop chain to s. Reset 0.
- Debounce: regs lvl (reset 0) and cnt (width clog2(DEB_CYCLES+1), reset 0).
  - s == lvl: cnt <= 0.
  - s != lvl and cnt == DEB_CYCLES-1: lvl <= s, cnt <= 0.
  - otherwise cnt <= cnt+1. Any sample with s == lvl restarts the count, so glitches shorter than DEB_CYCLES are rejected.
- Edge detect: lvl_d <= lvl (reset 0); rise = lvl & ~lvl_d, fall = ~lvl & lvl_d.
- Edge term: rise (mode 0), fall (mode 1), rise|fall (mode 2). EDGE_MODE 3 behaves as mode 0.
- Repeat FSM (REPEAT_EN=1 only; otherwise stays IDLE); timer width clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1), reset 0.
  - IDLE: on rise -> HOLD, timer <= 0.
  - HOLD: timer++; when timer == HOLD_CYCLES-1 -> REPEAT, timer <= 0, repeat term = 1.
  - REPEAT: timer++; when timer == REPEAT_CYCLES-1 -> timer <= 0, repeat term = 1.
  - lvl == 0 in HOLD or REPEAT -> IDLE, timer <= 0, repeat term = 0. This has priority over timer expiry.
- out_pulse[i] <= edge term | repeat term. level = lvl; held = (state == REPEAT).
- In EDGE_MODE 1 with repeat on, the press produces no pulse; repeats still fire while held, and release produces a pulse.

## Timing
- Reset: all flops 0. out_pulse, level and held are 0, FSM is IDLE. Assertion at any time, including mid-debounce or mid-repeat, aborts immediately. After release the channel restarts from level 0. An input already high at release yields a press pulse after full latency.
- Let k be the first clk edge sampling in_trig high, held stable:
  - level rises after edge k+SYNC_STAGES+DEB_CYCLES-1.
  - out_pulse is high for exactly one cycle after edge k+SYNC_STAGES+DEB_CYCLES (defaults: k+18).
- Release latency is symmetric.
- Repeat: with E = the edge that raised the press pulse, repeat pulses follow edges E+HOLD_CYCLES, E+HOLD_CYCLES+REPEAT_CYCLES, and so on. held rises with the first repeat pulse.
- Pulses are never longer than one cycle, except when two terms fall on adjacent edges; each remains a distinct registered cycle.
- HOLD_CYCLES=1 or REPEAT_CYCLES=1: a repeat pulse every cycle is legal.

## Test plan
- Clean press, defaults: in_trig[0] high from edge 10 for 100 cycles -> level[0] rises after edge 27, out_pulse[0] = 1 only after edge 28; other channels stay 0.
- Bounce: in_trig[1] toggles every 5 cycles for 60 cycles then stays high -> no pulse during bouncing; exactly one pulse 18 edges after the last toggle.
- EDGE_MODE=2, DEB_CYCLES=4: 20-cycle press -> pulse 6 edges after press start and 6 edges after release; exactly 2 pulses total.
- REPEAT_EN=1, HOLD_CYCLES=10, REPEAT_CYCLES=3, held 30 cycles after the press pulse at edge E -> pulses at E, E+10, E+13, E+16, …, E+28. held rises at E+10. Release returns the FSM to IDLE with no further pulses.
- Reset mid-repeat: assert rst_n=0 during REPEAT -> out_pulse, level and held are 0 at once. With the input still high after release -> one press pulse at SYNC_STAGES+DEB_CYCLES edges.
- Simultaneous: all N inputs press on the same edge with differing durations -> identical pulse timing per channel; short (<DEB_CYCLES) glitches on one channel do not affect the others.
